// File: rtl/instr_mem_block_pkg.sv
// ----------------------------------------------------------------------------
// instr_mem_block_pkg
//   Shared definitions for the instruction store and the measurement sequencer
//   (logic_control). An instruction is {dev, data}: a 4-bit device code in the
//   top bits and a 16-bit operand below it. Device code 0 means NOP / end.
// ----------------------------------------------------------------------------
package instr_mem_block_pkg;

    localparam int unsigned DEV_W    = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned INSTR_W  = DEV_W + DATA_W;

    // Field positions inside an instruction word
    localparam int unsigned DEV_MSB  = 19;
    localparam int unsigned DEV_LSB  = 16;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 0;

    localparam logic [DEV_W-1:0] DEV_NOP = 4'd0;

    // Host write assembly: first half-word carries the device, second the operand
    typedef enum logic {
        PhDev  = 1'b0,
        PhData = 1'b1
    } wr_phase_e;

    function automatic logic [INSTR_W-1:0] pack_instr(input logic [DEV_W-1:0]  dev,
                                                      input logic [DATA_W-1:0] data);
        return {dev, data};
    endfunction

    function automatic logic [DEV_W-1:0] instr_dev(input logic [INSTR_W-1:0] instr);
        return instr[DEV_MSB:DEV_LSB];
    endfunction

    function automatic logic [DATA_W-1:0] instr_data(input logic [INSTR_W-1:0] instr);
        return instr[DATA_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/instr_mem_block_ram.sv
// ----------------------------------------------------------------------------
// instr_mem_block_ram (instr_ram)
//   Simple dual-port instruction RAM, DEPTH x INSTR_W.
//   Synchronous write port; synchronous registered read port. The array and
//   the read register are not reset: contents are undefined until written.
// Ports
//   clk        system clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  instruction to store
//   i_rd_en    read strobe; o_rd_data updates on the following edge and holds
//   i_rd_addr  read address
//   o_rd_data  registered read data
// ----------------------------------------------------------------------------
module instr_mem_block_ram
    import instr_mem_block_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [INSTR_W-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [INSTR_W-1:0] o_rd_data
);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_mem_block.sv
// ----------------------------------------------------------------------------
// instr_mem_block
//   Program store feeding the measurement sequencer. The host loads each
//   instruction as two 16-bit words (device code, then operand); the sequencer
//   pulls instructions one per rising edge of mblock_en and receives
//   {dev_no, data_bus} one cycle later. mblock_clr rewinds for replay without
//   erasing; prog_clr erases the program. Linear store, pointers never wrap.
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   i_prog_clr       erase program (highest priority)
//   i_wr_en/wr_data  host half-word write
//   i_mblock_en      fetch request level (advances once per rising edge)
//   i_mblock_clr     rewind read pointer to 0
//   o_mblock_valid   unread instruction available
//   o_dev_no         fetched device code (0 = NOP/end)
//   o_data_bus       fetched operand
//   o_prog_count     instructions stored (0..DEPTH)
//   o_wr_pending     first half-word held, second awaited
//   o_overflow       sticky: write attempted while full
// ----------------------------------------------------------------------------
module instr_mem_block
    import instr_mem_block_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_prog_clr,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_mblock_en,
    input  logic              i_mblock_clr,
    output logic              o_mblock_valid,
    output logic [DEV_W-1:0]  o_dev_no,
    output logic [DATA_W-1:0] o_data_bus,
    output logic [ADDR_W:0]   o_prog_count,
    output logic              o_wr_pending,
    output logic              o_overflow
);

    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W:0]    r_wr_ptr;
    logic [ADDR_W:0]    r_rd_ptr;
    wr_phase_e          r_phase;
    logic [DEV_W-1:0]   r_dev_latch;
    logic               r_en_d;
    logic               r_overflow;
    logic [DEV_W-1:0]   r_dev_no;
    logic [DATA_W-1:0]  r_data_bus;
    // A fetch was accepted last cycle; r_load_nop marks a past-the-end fetch
    logic               r_load;
    logic               r_load_nop;

    logic               w_fetch;
    logic               w_has_entry;
    logic               w_full;
    logic               w_ram_wr;
    logic               w_ram_rd;
    logic [INSTR_W-1:0] w_rd_data;

    assign w_fetch     = i_mblock_en & ~r_en_d;
    assign w_has_entry = (r_rd_ptr < r_wr_ptr);
    assign w_full      = (r_wr_ptr == PTR_FULL);

    // prog_clr and mblock_clr both suppress the fetch in their cycle
    assign w_ram_rd = w_fetch & w_has_entry & ~i_prog_clr & ~i_mblock_clr;
    assign w_ram_wr = i_wr_en & (r_phase == PhData) & ~w_full & ~i_prog_clr;

    instr_mem_block_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_ram_wr),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (pack_instr(r_dev_latch, i_wr_data)),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_phase     <= PhDev;
            r_dev_latch <= '0;
            r_en_d      <= 1'b0;
            r_overflow  <= 1'b0;
            r_dev_no    <= '0;
            r_data_bus  <= '0;
            r_load      <= 1'b0;
            r_load_nop  <= 1'b0;
        end else begin
            r_load <= 1'b0;

            // Complete last cycle's fetch now that the RAM read has landed
            if (r_load) begin
                r_dev_no   <= r_load_nop ? DEV_NOP : instr_dev(w_rd_data);
                r_data_bus <= r_load_nop ? '0 : instr_data(w_rd_data);
            end

            if (i_prog_clr) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_phase    <= PhDev;
                r_overflow <= 1'b0;
                r_dev_no   <= '0;
                r_data_bus <= '0;
                r_en_d     <= i_mblock_en;
            end else begin
                // Fetch path
                if (i_mblock_clr) begin
                    r_rd_ptr <= '0;
                    r_en_d   <= 1'b0;
                end else begin
                    r_en_d <= i_mblock_en;
                    if (w_fetch) begin
                        r_load     <= 1'b1;
                        r_load_nop <= ~w_has_entry;
                        if (w_has_entry) begin
                            r_rd_ptr <= r_rd_ptr + PTR_ONE;
                        end
                    end
                end

                // Write assembly path
                if (i_wr_en) begin
                    if (r_phase == PhDev) begin
                        r_dev_latch <= i_wr_data[DEV_W-1:0];
                        r_phase     <= PhData;
                    end else begin
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        end
                        r_phase <= PhDev;
                    end
                end
            end
        end
    end

    assign o_mblock_valid = w_has_entry;
    assign o_dev_no       = r_dev_no;
    assign o_data_bus     = r_data_bus;
    assign o_prog_count   = r_wr_ptr;
    assign o_wr_pending   = (r_phase == PhData);
    assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_instr_mem_block.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_block
//   Self-checking bench for instr_mem_block. A queue-based program model
//   tracks the stored program, read index, half-word phase and the fetched
//   instruction (visible one cycle after the fetch edge). Every cycle the DUT
//   outputs are compared with the model; directed vectors add hand-computed
//   expectations.
// ----------------------------------------------------------------------------
module tb_instr_mem_block;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        prog_clr;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        mblock_en;
    logic        mblock_clr;
    logic        mblock_valid;
    logic [3:0]  dev_no;
    logic [15:0] data_bus;
    logic [8:0]  prog_count;
    logic        wr_pending;
    logic        overflow;

    instr_mem_block #(
        .DEPTH  (DEPTH),
        .ADDR_W (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_prog_clr     (prog_clr),
        .i_wr_en        (wr_en),
        .i_wr_data      (wr_data),
        .i_mblock_en    (mblock_en),
        .i_mblock_clr   (mblock_clr),
        .o_mblock_valid (mblock_valid),
        .o_dev_no       (dev_no),
        .o_data_bus     (data_bus),
        .o_prog_count   (prog_count),
        .o_wr_pending   (wr_pending),
        .o_overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    logic [19:0] m_prog [$];
    int          m_rd;
    bit          m_half;
    logic [3:0]  m_dev;
    bit          m_ovf;
    bit          m_prev_en;
    logic [19:0] m_out;
    bit          m_pend;
    logic [19:0] m_pend_val;

    function automatic void m_reset();
        m_prog.delete();
        m_rd      = 0;
        m_half    = 0;
        m_dev     = '0;
        m_ovf     = 0;
        m_prev_en = 0;
        m_out     = '0;
        m_pend    = 0;
        m_pend_val = '0;
    endfunction

    // One clock edge with the given inputs
    function automatic void m_step(bit clr, bit we, logic [15:0] wd, bit en, bit mclr);
        bit fetch;
        bit next_pend;
        fetch     = en && !m_prev_en;
        next_pend = 0;
        if (m_pend) m_out = m_pend_val;
        if (clr) begin
            m_prog.delete();
            m_rd      = 0;
            m_half    = 0;
            m_ovf     = 0;
            m_out     = '0;
            m_prev_en = en;
        end else begin
            if (mclr) begin
                m_rd      = 0;
                m_prev_en = 0;
            end else begin
                m_prev_en = en;
                if (fetch) begin
                    next_pend = 1;
                    if (m_rd < m_prog.size()) begin
                        m_pend_val = m_prog[m_rd];
                        m_rd++;
                    end else begin
                        m_pend_val = '0;
                    end
                end
            end
            if (we) begin
                if (!m_half) begin
                    m_dev  = wd[3:0];
                    m_half = 1;
                end else begin
                    if (m_prog.size() < DEPTH) m_prog.push_back({m_dev, wd});
                    else m_ovf = 1;
                    m_half = 0;
                end
            end
        end
        m_pend = next_pend;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 32'(mblock_valid), 32'(m_rd < m_prog.size()));
        chk({tag, ".dev"},   32'(dev_no),       32'(m_out[19:16]));
        chk({tag, ".data"},  32'(data_bus),     32'(m_out[15:0]));
        chk({tag, ".count"}, 32'(prog_count),   32'(m_prog.size()));
        chk({tag, ".pend"},  32'(wr_pending),   32'(m_half));
        chk({tag, ".ovf"},   32'(overflow),     32'(m_ovf));
    endtask

    // Drive inputs, take one edge, advance model, sample 1 time unit later
    task automatic cyc(input string tag, input bit clr, input bit we, input logic [15:0] wd,
                       input bit en, input bit mclr);
        prog_clr   = clr;
        wr_en      = we;
        wr_data    = wd;
        mblock_en  = en;
        mblock_clr = mclr;
        @(posedge clk);
        m_step(clr, we, wd, en, mclr);
        #1;
        chk_model(tag);
    endtask

    typedef struct {
        bit          clr;
        bit          we;
        logic [15:0] wd;
        bit          en;
        bit          mclr;
        bit          e_valid;
        logic [3:0]  e_dev;
        logic [15:0] e_data;
        int          e_count;
        bit          e_pend;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // Loading two instructions, fetching both, past-the-end NOP, rewind
        vecs[0]  = '{0, 1, 16'h0001, 0, 0,  0, 4'h0, 16'h0000, 0, 1};
        vecs[1]  = '{0, 1, 16'h1234, 0, 0,  1, 4'h0, 16'h0000, 1, 0};
        vecs[2]  = '{0, 1, 16'h0003, 0, 0,  1, 4'h0, 16'h0000, 1, 1};
        vecs[3]  = '{0, 1, 16'hABCD, 0, 0,  1, 4'h0, 16'h0000, 2, 0};
        vecs[4]  = '{0, 0, 16'h0000, 1, 0,  1, 4'h0, 16'h0000, 2, 0};
        vecs[5]  = '{0, 0, 16'h0000, 1, 0,  1, 4'h1, 16'h1234, 2, 0};
        vecs[6]  = '{0, 0, 16'h0000, 0, 0,  1, 4'h1, 16'h1234, 2, 0};
        vecs[7]  = '{0, 0, 16'h0000, 1, 0,  0, 4'h1, 16'h1234, 2, 0};
        vecs[8]  = '{0, 0, 16'h0000, 0, 0,  0, 4'h3, 16'hABCD, 2, 0};
        vecs[9]  = '{0, 0, 16'h0000, 1, 0,  0, 4'h3, 16'hABCD, 2, 0};
        vecs[10] = '{0, 0, 16'h0000, 0, 0,  0, 4'h0, 16'h0000, 2, 0};
        vecs[11] = '{0, 0, 16'h0000, 0, 1,  1, 4'h0, 16'h0000, 2, 0};
        vecs[12] = '{0, 0, 16'h0000, 1, 0,  1, 4'h0, 16'h0000, 2, 0};
        vecs[13] = '{0, 0, 16'h0000, 0, 0,  1, 4'h1, 16'h1234, 2, 0};
    end

    logic [3:0]  exp_dev;
    logic [15:0] exp_data;

    initial begin
        rst        = 1'b1;
        prog_clr   = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        mblock_en  = 1'b0;
        mblock_clr = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {23'd0, mblock_valid, dev_no, data_bus[2:0], wr_pending, overflow}, 32'd0);
        chk("reset.data", 32'(data_bus), 32'd0);
        chk("reset.count", 32'(prog_count), 32'd0);
        rst = 1'b0;

        // ---- directed table ----
        for (int i = 0; i < 14; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].clr, vecs[i].we, vecs[i].wd, vecs[i].en,
                vecs[i].mclr);
            chk($sformatf("vec%0d.t_valid", i), 32'(mblock_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.t_dev", i),   32'(dev_no),       32'(vecs[i].e_dev));
            chk($sformatf("vec%0d.t_data", i),  32'(data_bus),     32'(vecs[i].e_data));
            chk($sformatf("vec%0d.t_count", i), 32'(prog_count),   32'(vecs[i].e_count));
            chk($sformatf("vec%0d.t_pend", i),  32'(wr_pending),   32'(vecs[i].e_pend));
        end

        // ---- held mblock_en: one advance per rising edge ----
        cyc("hold.rw", 0, 0, 16'h0, 0, 1);
        cyc("hold2.a", 0, 0, 16'h0, 1, 0);
        cyc("hold2.b", 0, 0, 16'h0, 1, 0);
        chk("hold2.dev_after_1", 32'(dev_no), 32'h1);
        cyc("hold.gap", 0, 0, 16'h0, 0, 0);
        for (int i = 0; i < 5; i++) cyc($sformatf("hold5.%0d", i), 0, 0, 16'h0, 1, 0);
        chk("hold5.dev", 32'(dev_no), 32'h3);
        chk("hold5.data", 32'(data_bus), 32'hABCD);
        chk("hold5.valid", 32'(mblock_valid), 32'h0);
        cyc("hold.end", 0, 0, 16'h0, 0, 0);

        // ---- fill to DEPTH then overflow ----
        cyc("fill.clr", 1, 0, 16'h0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc("fill.d", 0, 1, 16'((i % 15) + 1), 0, 0);
            cyc("fill.w", 0, 1, 16'(i * 257) ^ 16'h5A5A, 0, 0);
        end
        chk("fill.count", 32'(prog_count), 32'(DEPTH));
        chk("fill.ovf0", 32'(overflow), 32'h0);
        cyc("ovf.d", 0, 1, 16'h000F, 0, 0);
        cyc("ovf.w", 0, 1, 16'hFFFF, 0, 0);
        chk("ovf.count", 32'(prog_count), 32'(DEPTH));
        chk("ovf.flag", 32'(overflow), 32'h1);
        cyc("rd.rw", 0, 0, 16'h0, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc("rd.f", 0, 0, 16'h0, 1, 0);
            cyc("rd.o", 0, 0, 16'h0, 0, 0);
            if (i == 0 || i == DEPTH - 1) begin
                exp_dev  = 4'((i % 15) + 1);
                exp_data = 16'(i * 257) ^ 16'h5A5A;
                chk($sformatf("rd%0d.dev", i),  32'(dev_no),   32'(exp_dev));
                chk($sformatf("rd%0d.data", i), 32'(data_bus), 32'(exp_data));
            end
        end

        // ---- prog_clr ----
        cyc("pc.w", 0, 1, 16'h0002, 0, 0);
        cyc("pc.clr", 1, 0, 16'h0, 0, 0);
        chk("pc.pend", 32'(wr_pending), 32'h0);
        chk("pc.count", 32'(prog_count), 32'h0);
        chk("pc.ovf", 32'(overflow), 32'h0);
        cyc("pc2.w", 0, 1, 16'h0004, 0, 0);
        cyc("pc2.clrw", 1, 1, 16'h1111, 0, 0);
        cyc("pc3.clrw", 1, 1, 16'h0005, 0, 0);
        chk("pc3.count", 32'(prog_count), 32'h0);
        chk("pc3.pend", 32'(wr_pending), 32'h0);

        // ---- async reset between half-words ----
        cyc("ar.w", 0, 1, 16'h0006, 0, 0);
        wr_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("ar.pend", 32'(wr_pending), 32'h0);
        chk("ar.outs", {27'd0, mblock_valid, overflow, 3'd0} | 32'(dev_no), 32'h0);
        chk("ar.count", 32'(prog_count), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("ar.d", 0, 1, 16'h0009, 0, 0);
        chk("ar.pend1", 32'(wr_pending), 32'h1);
        cyc("ar.v", 0, 1, 16'h0042, 0, 0);
        cyc("ar.f", 0, 0, 16'h0, 1, 0);
        cyc("ar.o", 0, 0, 16'h0, 0, 0);
        chk("ar.count1", 32'(prog_count), 32'h1);
        chk("ar.dev", 32'(dev_no), 32'h9);
        chk("ar.data", 32'(data_bus), 32'h0042);

        // ---- randomized traffic against the model ----
        cyc("rnd.clr", 1, 0, 16'h0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            cyc("rnd", ($urandom_range(99) == 0), $urandom_range(1) == 1,
                16'($urandom), $urandom_range(1) == 1, ($urandom_range(7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
